// File: rtl/vecmon_pkg.sv
// vecmon_pkg: shared types and default sizing for the vecmon counter monitor.
//   state_t       - tracking state (IDLE, RUN, FAULT)
//   VECMON_CW     - default width of the monitored wrapping counter
//   VECMON_EW     - default width of the extended count and of records
//   VECMON_DEPTH  - default record FIFO depth (power of two, >= 2)
package vecmon_pkg;

    localparam int unsigned VECMON_CW    = 3;
    localparam int unsigned VECMON_EW    = 16;
    localparam int unsigned VECMON_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/vecmon_fifo.sv
// vecmon_fifo: small synchronous record FIFO with asynchronous reset.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (empties the FIFO)
//   push       - write push_data this cycle (ignored when full without pop)
//   push_data  - record to write
//   pop        - remove head record this cycle (ignored when empty)
//   full       - DEPTH records held
//   empty      - no records held
//   head       - current head record (0 after reset)
module vecmon_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop. An empty FIFO is never bypassed.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vecmon.sv
// vecmon: monitors a wrapping counter value, rebuilds an unwrapped count,
// flags skipped steps and records the extended count on every wrap.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - sample enable; tracking state holds when low
//   v         - wrapping counter value from upstream
//   clr       - synchronous pulse clearing err/ovf and leaving FAULT
//   ext_cnt   - extended (unwrapped) count, registered
//   out_data  - head record of the FIFO
//   out_vld   - FIFO non-empty
//   out_rdy   - consumer accepts head record when out_vld && out_rdy
//   err       - sticky skip error
//   ovf       - sticky record-drop flag
module vecmon
    import vecmon_pkg::*;
#(
    parameter int unsigned CW    = VECMON_CW,
    parameter int unsigned EW    = VECMON_EW,
    parameter int unsigned DEPTH = VECMON_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] v,
    input  logic          clr,
    output logic [EW-1:0] ext_cnt,
    output logic [EW-1:0] out_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic          err,
    output logic          ovf
);

    state_t        state;
    logic [CW-1:0] v_q;
    logic [CW-1:0] delta;
    logic [EW-1:0] ext_next;
    logic          active;
    logic          skip;
    logic          wrap;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;

    // Modular difference gives the number of upstream steps since last sample.
    assign delta    = v - v_q;
    assign ext_next = ext_cnt + EW'(delta);
    assign active   = en && (state != ST_IDLE);
    assign skip     = active && (delta > CW'(1));
    // v below v_q implies a nonzero delta, so it alone marks a wrap.
    assign wrap     = active && (v < v_q);

    assign pop      = out_vld && out_rdy;
    assign drop     = wrap && full && !pop;
    assign out_vld  = !empty;

    vecmon_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wrap),
        .push_data (ext_next),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (out_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            v_q     <= '0;
            ext_cnt <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (en) begin
                v_q <= v;
                if (state == ST_IDLE) begin
                    ext_cnt <= EW'(v);
                end else begin
                    ext_cnt <= ext_next;
                end
            end

            // A new skip or drop outranks a simultaneous clr.
            if (skip) begin
                err <= 1'b1;
            end else if (clr) begin
                err <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (skip) begin
                        state <= ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (clr && !skip) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vecmon.sv
// tb_vecmon: scoreboard bench for vecmon. Stimulus pushes expected records
// into a queue; a monitor pops and compares on every out_vld && out_rdy.
module tb_vecmon;

    localparam int unsigned CW    = 3;
    localparam int unsigned EW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [CW-1:0] v   = '0;
    logic          clr = 1'b0;
    logic          out_rdy = 1'b0;
    logic [EW-1:0] ext_cnt;
    logic [EW-1:0] out_data;
    logic          out_vld;
    logic          err;
    logic          ovf;

    int            checks   = 0;
    int            failures = 0;
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] e;

    always #5 clk = ~clk;

    vecmon #(
        .CW    (CW),
        .EW    (EW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .v        (v),
        .clr      (clr),
        .ext_cnt  (ext_cnt),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .err      (err),
        .ovf      (ovf)
    );

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Inputs applied here are sampled at the next posedge; outputs are
    // observed 1 time unit after that edge.
    task automatic cyc(input logic e_i, input logic [CW-1:0] vv, input logic r, input logic c);
        en      = e_i;
        v       = vv;
        out_rdy = r;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b0;
        v       = '0;
        out_rdy = 1'b0;
        clr     = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every accepted record must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record: got %0d expected none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("record", out_data, mon_exp);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and plain counting with one wrap.
        do_reset();
        chk("rst_ext", ext_cnt, 0);
        chk("rst_vld", EW'(out_vld), 0);
        chk("rst_data", out_data, 0);
        chk("rst_err", EW'(err), 0);
        chk("rst_ovf", EW'(ovf), 0);
        for (int i = 0; i < 8; i++) cyc(1'b1, CW'(i), 1'b1, 1'b0);
        chk("count_ext7", ext_cnt, 7);
        exp_q.push_back(16'd8);
        cyc(1'b1, 3'd0, 1'b1, 1'b0);
        chk("wrap_latency_vld", EW'(out_vld), 1);
        chk("wrap_latency_data", out_data, 8);
        cyc(1'b1, 3'd1, 1'b1, 1'b0);
        chk("count_ext9", ext_cnt, 9);
        chk("count_vld0", EW'(out_vld), 0);
        chk("count_err", EW'(err), 0);

        // Skip detection, clr, and skip winning over a simultaneous clr.
        do_reset();
        cyc(1'b1, 3'd0, 1'b1, 1'b0);
        cyc(1'b1, 3'd1, 1'b1, 1'b0);
        cyc(1'b1, 3'd2, 1'b1, 1'b0);
        chk("pre_skip_err", EW'(err), 0);
        cyc(1'b1, 3'd5, 1'b1, 1'b0);
        chk("skip_err", EW'(err), 1);
        chk("skip_ext", ext_cnt, 5);
        cyc(1'b1, 3'd5, 1'b1, 1'b1);
        chk("clr_err", EW'(err), 0);
        exp_q.push_back(16'd8);
        cyc(1'b1, 3'd0, 1'b1, 1'b1);
        chk("clr_vs_skip_err", EW'(err), 1);
        chk("clr_vs_skip_ext", ext_cnt, 8);
        cyc(1'b1, 3'd0, 1'b1, 1'b1);
        chk("clr2_err", EW'(err), 0);

        // Overflow: five wraps with consumer stalled.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 3'd6, 1'b0, 1'b0);
            cyc(1'b1, 3'd7, 1'b0, 1'b0);
            if (k < 4) exp_q.push_back(EW'(8 * (k + 1)));
            cyc(1'b1, 3'd0, 1'b0, 1'b0);
            if (k == 3) chk("full_no_ovf", EW'(ovf), 0);
        end
        chk("ovf_set", EW'(ovf), 1);
        chk("ovf_ext", ext_cnt, 40);
        chk("ovf_held_data", out_data, 8);
        chk("ovf_held_vld", EW'(out_vld), 1);
        repeat (5) cyc(1'b1, 3'd0, 1'b1, 1'b0);
        chk("ovf_drained_vld", EW'(out_vld), 0);
        chk("ovf_sticky", EW'(ovf), 1);
        cyc(1'b1, 3'd0, 1'b0, 1'b1);
        chk("ovf_clr", EW'(ovf), 0);
        chk("ovf_q_empty", EW'(exp_q.size()), 0);

        // Full FIFO with pop in the same cycle as a new wrap.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 3'd6, 1'b0, 1'b0);
            cyc(1'b1, 3'd7, 1'b0, 1'b0);
            exp_q.push_back(EW'(8 * (k + 1)));
            cyc(1'b1, 3'd0, 1'b0, 1'b0);
        end
        cyc(1'b1, 3'd6, 1'b0, 1'b0);
        cyc(1'b1, 3'd7, 1'b0, 1'b0);
        exp_q.push_back(16'd40);
        cyc(1'b1, 3'd0, 1'b1, 1'b0);
        chk("poppush_ovf", EW'(ovf), 0);
        chk("poppush_head", out_data, 16);
        repeat (5) cyc(1'b1, 3'd0, 1'b1, 1'b0);
        chk("poppush_q_empty", EW'(exp_q.size()), 0);
        chk("poppush_vld0", EW'(out_vld), 0);

        // en low holds tracking while v advances.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, CW'(i), 1'b1, 1'b0);
        cyc(1'b0, 3'd4, 1'b1, 1'b0);
        cyc(1'b0, 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 3'd6, 1'b1, 1'b0);
        chk("en0_ext", ext_cnt, 3);
        chk("en0_err", EW'(err), 0);
        cyc(1'b1, 3'd6, 1'b1, 1'b0);
        chk("en1_skip_err", EW'(err), 1);
        chk("en1_ext", ext_cnt, 6);

        // Asynchronous reset with two records pending, then re-arm.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 3'd6, 1'b0, 1'b0);
            cyc(1'b1, 3'd7, 1'b0, 1'b0);
            cyc(1'b1, 3'd0, 1'b0, 1'b0);
        end
        chk("pending_vld", EW'(out_vld), 1);
        chk("pending_ext", ext_cnt, 16);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vld", EW'(out_vld), 0);
        chk("async_rst_ext", ext_cnt, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_err", EW'(err), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 3'd5, 1'b1, 1'b0);
        chk("rearm_ext", ext_cnt, 5);
        chk("rearm_err", EW'(err), 0);
        cyc(1'b1, 3'd6, 1'b1, 1'b0);
        chk("rearm_ext2", ext_cnt, 6);
        chk("rearm_vld", EW'(out_vld), 0);

        // ext_cnt wraps past 2^EW-1: v steps by 7 (delta 7) each cycle.
        do_reset();
        cyc(1'b1, 3'd0, 1'b1, 1'b0);
        e = '0;
        for (int i = 1; i <= 9362; i++) begin
            e = e + 16'd7;
            if (((i - 1) % 8) != 0) exp_q.push_back(e);
            cyc(1'b1, CW'((7 * i) % 8), 1'b1, 1'b0);
        end
        chk("ext_near_max", ext_cnt, 65534);
        e = e + 16'd7;
        exp_q.push_back(e);
        cyc(1'b1, 3'd5, 1'b1, 1'b0);
        chk("ext_wrapped", ext_cnt, 5);
        repeat (3) cyc(1'b1, 3'd5, 1'b1, 1'b0);
        chk("ext_q_empty", EW'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vecmon.md
VECMON -- requirements
Module: vecmon

Interface
REQ-001 Parameter CW, default 3, width of the monitored counter value.
REQ-002 Parameter EW, default 16, width of the extended count and of output records.
REQ-003 Parameter DEPTH, default 4, record FIFO depth, power of two, minimum 2.
REQ-004 clk  input  1  single clock, all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  sample enable; when 0, all tracking state holds.
REQ-007 v  input  CW  wrapping counter value from the upstream counter stage.
REQ-008 clr  input  1  synchronous pulse; clears err and ovf, FAULT->RUN.
REQ-009 ext_cnt  output  EW  extended (unwrapped) count, registered.
REQ-010 out_data  output  EW  head record of the FIFO.
REQ-011 out_vld  output  1  FIFO non-empty.
REQ-012 out_rdy  input  1  consumer accepts head record when out_vld&&out_rdy.
REQ-013 err  output  1  sticky skip error.
REQ-014 ovf  output  1  sticky record-drop flag.

Function
REQ-015 States IDLE, RUN, FAULT; IDLE->RUN on first cycle with en=1, capturing v into v_q, ext_cnt <= zero-extended v, no checks, no record.
REQ-016 In RUN/FAULT with en=1: delta = (v - v_q) mod 2^CW; v_q <= v; ext_cnt <= ext_cnt + delta (mod 2^EW).
REQ-017 delta=0: hold; delta=1: normal step; delta>=2: skip, err <= 1, RUN->FAULT.
REQ-018 Wrap event: v < v_q with delta nonzero (including a wrap that is also a skip); push new ext_cnt value as record.
REQ-019 FAULT continues tracking and recording exactly as RUN; only clr or rst leaves it.
REQ-020 clr in same cycle as a new skip: skip wins, err stays 1, state FAULT; ovf cleared unless same-cycle drop.
REQ-021 en=0: v_q, ext_cnt, state hold; FIFO pop still operates.
REQ-022 Record visible on out_data/out_vld the cycle after the wrap sample (1-cycle latency).
REQ-023 out_data stable and out_vld held while out_vld&&!out_rdy.
REQ-024 Push when full and no pop: record dropped, ovf <= 1, FIFO unchanged.
REQ-025 Push when full with pop same cycle: pop and push both accepted, count unchanged.
REQ-026 Push and pop when empty: FIFO is not bypassed; record appears next cycle.
REQ-027 ext_cnt wraps from 2^EW-1 to 0 silently.

Reset
REQ-028 rst=1 asynchronously forces: state IDLE, v_q 0, ext_cnt 0, FIFO empty, out_vld 0, out_data 0, err 0, ovf 0.
REQ-029 rst mid-operation discards all FIFO contents; first en=1 after release re-arms as in REQ-015.

Structure
REQ-030 Package vecmon_pkg holds state enum type, default CW/EW/DEPTH constants.
REQ-031 FIFO is one sub-module vecmon_fifo (push, pop, full, empty, head data), instantiated once.
REQ-032 Delta, skip and wrap detection and state machine reside in vecmon top.

Verification
REQ-033 Reset release, en=1, v counts 0..7,0,1 one per cycle, out_rdy=1 -> single record 8, ext_cnt=9, err=0.
REQ-034 v sequence 0,1,2,5 -> err=1 one cycle after the 5 sample, state FAULT, ext_cnt=5; clr pulse -> err=0, RUN.
REQ-035 out_rdy=0, 5 consecutive wraps (v steps 6,7,0 repeated... yielding records 8,16,24,32,40) -> records 8,16,24,32 held, 40 dropped, ovf=1.
REQ-036 FIFO full, out_rdy=1 same cycle as new wrap -> 8 popped, new record accepted, ovf stays 0.
REQ-037 en toggled 0 for 3 cycles while v advances 3->6, then en=1 with v=6 -> skip flagged, ext_cnt += 3.
REQ-038 rst asserted asynchronously with 2 records pending -> out_vld=0, ext_cnt=0 immediately, no clock edge needed.
